// File: rtl/conversor_bcd_if.sv
// Handshake and result bus of the BCD converter: the requester drives start/s/mag,
// the converter returns status, BCD digits and seven-segment patterns.
interface conversor_bcd_if;
    logic       start;
    logic       s;
    logic [4:0] mag;
    logic       busy;
    logic       done;
    logic       neg;
    logic [3:0] dezena;
    logic [3:0] unidade;
    logic [6:0] seg_dez;
    logic [6:0] seg_uni;

    modport master (
        output start, s, mag,
        input  busy, done, neg, dezena, unidade, seg_dez, seg_uni
    );

    modport slave (
        input  start, s, mag,
        output busy, done, neg, dezena, unidade, seg_dez, seg_uni
    );
endinterface

// File: rtl/conversor_bcd.sv
// Signed 5-bit magnitude to two-digit BCD converter (double dabble, one bit per cycle)
// with registered seven-segment patterns for the tens and units digits.
module conversor_bcd (
    input  logic             clk,
    input  logic             rst,
    conversor_bcd_if.slave   bus
);
    localparam int unsigned MAG_W = 5;
    localparam int unsigned BCD_W = 8;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned STEPS = 5;
    localparam int unsigned SEG_W = 7;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_ZERO  = 7'b1000000;

    // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles are dark
    function automatic logic [SEG_W-1:0] seg7(input logic [3:0] d);
        logic [SEG_W-1:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

    logic [1:0]       r_state,   w_state;
    logic [CNT_W-1:0] r_cnt,     w_cnt;
    logic [BCD_W-1:0] r_bcd,     w_bcd;
    logic [MAG_W-1:0] r_sh,      w_sh;
    logic [MAG_W-1:0] r_mag,     w_mag;
    logic             r_sign,    w_sign;
    logic             r_busy,    w_busy;
    logic             r_done,    w_done;
    logic             r_neg,     w_neg;
    logic [3:0]       r_dez,     w_dez;
    logic [3:0]       r_uni,     w_uni;
    logic [SEG_W-1:0] r_seg_dez, w_seg_dez;
    logic [SEG_W-1:0] r_seg_uni, w_seg_uni;

    logic [3:0]             w_adj_hi;
    logic [3:0]             w_adj_lo;
    logic [BCD_W+MAG_W-1:0] w_cat;
    logic [CNT_W-1:0]       w_cnt_inc;

    // One double-dabble step: correct nibbles >= 5, then shift the whole chain left
    always_comb begin
        w_adj_hi  = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];
        w_adj_lo  = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
        w_cat     = {w_adj_hi, w_adj_lo, r_sh} << 1;
        w_cnt_inc = r_cnt + CNT_W'(1);
    end

    // Next-state and next-register logic
    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_bcd     = r_bcd;
        w_sh      = r_sh;
        w_mag     = r_mag;
        w_sign    = r_sign;
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_neg     = r_neg;
        w_dez     = r_dez;
        w_uni     = r_uni;
        w_seg_dez = r_seg_dez;
        w_seg_uni = r_seg_uni;

        case (r_state)
            S_IDLE: begin
                w_busy = bus.start;
                if (bus.start) begin
                    w_sign  = bus.s;
                    w_mag   = bus.mag;
                    w_sh    = bus.mag;
                    w_bcd   = '0;
                    w_cnt   = '0;
                    w_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_busy = 1'b1;
                w_bcd  = w_cat[BCD_W+MAG_W-1:MAG_W];
                w_sh   = w_cat[MAG_W-1:0];
                w_cnt  = w_cnt_inc;
                if (w_cnt_inc == CNT_W'(STEPS)) begin
                    w_state = S_DONE;
                end
            end
            S_DONE: begin
                // busy stays up through this edge so it drops one cycle after done
                w_busy    = 1'b1;
                w_done    = 1'b1;
                w_dez     = r_bcd[7:4];
                w_uni     = r_bcd[3:0];
                w_neg     = r_sign & (r_mag != '0);
                w_seg_uni = seg7(r_bcd[3:0]);
                w_seg_dez = (r_bcd[7:4] == 4'd0) ? SEG_BLANK : seg7(r_bcd[7:4]);
                w_state   = S_IDLE;
            end
            default: begin
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_sh      <= '0;
            r_mag     <= '0;
            r_sign    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_neg     <= 1'b0;
            r_dez     <= '0;
            r_uni     <= '0;
            r_seg_dez <= SEG_BLANK;
            r_seg_uni <= SEG_ZERO;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_bcd     <= w_bcd;
            r_sh      <= w_sh;
            r_mag     <= w_mag;
            r_sign    <= w_sign;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_neg     <= w_neg;
            r_dez     <= w_dez;
            r_uni     <= w_uni;
            r_seg_dez <= w_seg_dez;
            r_seg_uni <= w_seg_uni;
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.neg     = r_neg;
    assign bus.dezena  = r_dez;
    assign bus.unidade = r_uni;
    assign bus.seg_dez = r_seg_dez;
    assign bus.seg_uni = r_seg_uni;
endmodule

// File: tb/tb_conversor_bcd.sv
// Bench for conversor_bcd: directed and random stimulus compared every cycle against
// a cycle-count/arithmetic reference model, plus literal expectations for known cases.
module tb_conversor_bcd;
    logic clk = 1'b0;
    logic rst = 1'b1;
    conversor_bcd_if bus();

    conversor_bcd dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int         m_cnt = 0;
    logic       m_s;
    int         m_mag;
    logic       chk_en = 1'b0;
    logic       e_busy, e_done, e_neg;
    logic [3:0] e_dez, e_uni;
    logic [6:0] e_sd, e_su;

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        if (d < 0 || d > 9) return 7'b1111111;
        return tbl[d];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, $time, act, act, exp, exp);
        end
    endtask

    // Model: start accepted only when idle; results appear 7 edges after capture
    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; e_busy = 0; e_done = 0; e_neg = 0;
            e_dez = 0; e_uni = 0; e_sd = 7'b1111111; e_su = 7'b1000000;
            chk_en = 1'b1;
        end else if (m_cnt == 0) begin
            e_done = 0;
            e_busy = bus.start;
            if (bus.start) begin
                m_cnt = 1; m_s = bus.s; m_mag = int'(bus.mag);
            end
        end else begin
            m_cnt++;
            e_busy = 1;
            e_done = 0;
            if (m_cnt == 7) begin
                m_cnt  = 0;
                e_done = 1;
                e_dez  = 4'(m_mag / 10);
                e_uni  = 4'(m_mag % 10);
                e_neg  = m_s && (m_mag != 0);
                e_su   = seg_of(m_mag % 10);
                e_sd   = (m_mag / 10 == 0) ? 7'b1111111 : seg_of(m_mag / 10);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",    int'(bus.busy),    int'(e_busy));
            check("done",    int'(bus.done),    int'(e_done));
            check("neg",     int'(bus.neg),     int'(e_neg));
            check("dezena",  int'(bus.dezena),  int'(e_dez));
            check("unidade", int'(bus.unidade), int'(e_uni));
            check("seg_dez", int'(bus.seg_dez), int'(e_sd));
            check("seg_uni", int'(bus.seg_uni), int'(e_su));
        end
    end

    // Called at posedge+2; returns at a negedge where done is high (or bound expired)
    task automatic wait_done();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) return;
        end
        check("done_timeout", 0, 1);
    endtask

    task automatic to_drive_slot();
        @(posedge clk);
        #2;
    endtask

    // One-cycle start pulse; inputs scrambled after capture to show they are not reused
    task automatic convert(input logic sv, input logic [4:0] mv);
        bus.start = 1'b1; bus.s = sv; bus.mag = mv;
        to_drive_slot();
        bus.start = 1'b0;
        bus.s     = 1'($urandom_range(1, 0));
        bus.mag   = 5'($urandom_range(31, 0));
        wait_done();
    endtask

    initial begin
        bus.start = 1'b0; bus.s = 1'b0; bus.mag = '0;
        rst = 1'b1;
        to_drive_slot();
        to_drive_slot();
        rst = 1'b0;
        @(negedge clk);
        check("rst_seg_dez", int'(bus.seg_dez), 7'b1111111);
        check("rst_seg_uni", int'(bus.seg_uni), 7'b1000000);
        check("rst_busy",    int'(bus.busy),    0);
        to_drive_slot();

        // s=1, mag=23
        convert(1'b1, 5'd23);
        check("m23_neg", int'(bus.neg), 1);
        check("m23_dez", int'(bus.dezena), 2);
        check("m23_uni", int'(bus.unidade), 3);
        check("m23_sd",  int'(bus.seg_dez), 7'b0100100);
        check("m23_su",  int'(bus.seg_uni), 7'b0110000);
        check("m23_busy", int'(bus.busy), 1);
        to_drive_slot();
        @(negedge clk);
        check("m23_done_pulse", int'(bus.done), 0);
        check("m23_busy_low",   int'(bus.busy), 0);
        to_drive_slot();

        convert(1'b0, 5'd31);
        check("m31_dez", int'(bus.dezena), 3);
        check("m31_uni", int'(bus.unidade), 1);
        check("m31_neg", int'(bus.neg), 0);
        to_drive_slot();

        convert(1'b0, 5'd9);
        check("m9_dez", int'(bus.dezena), 0);
        check("m9_sd",  int'(bus.seg_dez), 7'b1111111);
        check("m9_uni", int'(bus.unidade), 9);
        to_drive_slot();

        convert(1'b1, 5'd0);
        check("negzero_neg", int'(bus.neg), 0);
        check("negzero_uni", int'(bus.unidade), 0);
        check("negzero_su",  int'(bus.seg_uni), 7'b1000000);
        check("negzero_sd",  int'(bus.seg_dez), 7'b1111111);
        to_drive_slot();

        // Second start during SHIFT is dropped
        bus.start = 1'b1; bus.s = 1'b0; bus.mag = 5'd12;
        to_drive_slot();
        bus.start = 1'b0; bus.mag = 5'd7;
        to_drive_slot();
        bus.start = 1'b1;
        to_drive_slot();
        bus.start = 1'b0;
        wait_done();
        check("drop_dez", int'(bus.dezena), 1);
        check("drop_uni", int'(bus.unidade), 2);
        repeat (10) to_drive_slot();

        // Reset in the third SHIFT cycle aborts the conversion
        bus.start = 1'b1; bus.s = 1'b1; bus.mag = 5'd27;
        to_drive_slot();
        bus.start = 1'b0;
        repeat (2) to_drive_slot();
        rst = 1'b1;
        to_drive_slot();
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_dez",  int'(bus.dezena), 0);
        check("abort_su",   int'(bus.seg_uni), 7'b1000000);
        repeat (9) to_drive_slot();
        convert(1'b0, 5'd18);
        check("after_abort_dez", int'(bus.dezena), 1);
        check("after_abort_uni", int'(bus.unidade), 8);
        repeat (3) to_drive_slot();

        // Start held high, mag stepped once per 7-cycle conversion
        bus.start = 1'b1; bus.s = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.mag = 5'(i);
            repeat (7) to_drive_slot();
        end
        bus.start = 1'b0;
        repeat (9) to_drive_slot();

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            bus.start = ($urandom_range(2, 0) == 0);
            bus.s     = 1'($urandom_range(1, 0));
            bus.mag   = 5'($urandom_range(31, 0));
            rst       = ($urandom_range(59, 0) == 0);
            to_drive_slot();
        end
        rst = 1'b0; bus.start = 1'b0;
        repeat (10) to_drive_slot();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
